uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` transmitter among `NREQ` requesters. It accepts a frame and its per-frame configuration from one requester at a time, starts the transmitter, and holds its inputs stable for the whole frame. It reports completion, error or timeout back to the requester that owns the frame. It sits between the client blocks and the transmitter, and drives all transmitter inputs including its reset.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx transmitter among NREQ requesters.
// Latency: gnt/uart_start two cycles after a request is captured in IDLE; done one cycle after uart_done.
// Backpressure: requesters hold req and fields until gnt; req is only sampled while IDLE.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              tx_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ*4-1:0] req_length,
  input  logic [NREQ-1:0]   req_parity_type,
  input  logic [NREQ-1:0]   req_parity_en,
  input  logic [NREQ-1:0]   req_stop2,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              uart_start,
  output logic [7:0]        uart_data,
  output logic [3:0]        uart_length,
  output logic              uart_parity_type,
  output logic              uart_parity_en,
  output logic              uart_stop2,
  output logic              uart_rst,
  input  logic              uart_done,
  input  logic              uart_err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_ABORT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic            urst_q, urst_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      len_q, len_d;
  logic            pt_q, pt_d;
  logic            pe_q, pe_d;
  logic            st2_q, st2_d;

  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [7:0]      sel_data;
  logic [3:0]      sel_len;
  logic            sel_pt, sel_pe, sel_st2;
  logic [NREQ-1:0] own_oh;
  logic            len_ok;

  // Pick the first active requester after the previous winner, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && req[IDW'((int'(ptr_q) + k) % NREQ)]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Select the winner's per-frame configuration fields.
  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    sel_pt   = 1'b0;
    sel_pe   = 1'b0;
    sel_st2  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_data = req_data[i*8 +: 8];
        sel_len  = req_length[i*4 +: 4];
        sel_pt   = req_parity_type[i];
        sel_pe   = req_parity_en[i];
        sel_st2  = req_stop2[i];
      end
    end
  end

  // ptr_q always names the owner of the frame in flight.
  assign own_oh = ONE << ptr_q;
  assign len_ok = (len_q >= 4'd5) && (len_q <= 4'd8);

  // Next-state and registered-output decode; every pulse defaults low.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    urst_d  = 1'b0;
    data_d  = data_q;
    len_d   = len_q;
    pt_d    = pt_q;
    pe_d    = pe_q;
    st2_d   = st2_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          ptr_d   = win_id;
          data_d  = sel_data;
          len_d   = sel_len;
          pt_d    = sel_pt;
          pe_d    = sel_pe;
          st2_d   = sel_st2;
          state_d = ST_START;
        end
      end
      ST_START: begin
        gnt_d = own_oh;
        cnt_d = '0;
        if (len_ok) begin
          start_d = 1'b1;
          state_d = ST_WAIT;
        end else begin
          err_d   = own_oh;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (uart_done) begin
          done_d  = own_oh;
          err_d   = uart_err ? own_oh : '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d   = own_oh;
          urst_d  = 1'b1;
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; the transmitter is held in reset with the arbiter.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      urst_q  <= 1'b1;
      data_q  <= '0;
      len_q   <= '0;
      pt_q    <= 1'b0;
      pe_q    <= 1'b0;
      st2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      urst_q  <= urst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      pt_q    <= pt_d;
      pe_q    <= pe_d;
      st2_q   <= st2_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign err              = err_q;
  assign busy             = busy_q;
  assign uart_start       = start_q;
  assign uart_rst         = urst_q;
  assign uart_data        = data_q;
  assign uart_length      = len_q;
  assign uart_parity_type = pt_q;
  assign uart_parity_en   = pe_q;
  assign uart_stop2       = st2_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a frame-level model.
// Latency: frame timing predicted from gnt = capture+2 and done = gnt+4+L+P+T.
// Backpressure: bench requesters hold req and fields until they see gnt.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              tx_clk = 1'b0;
  logic              rst_n  = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ*4-1:0] req_length = '0;
  logic [NREQ-1:0]   req_parity_type = '0;
  logic [NREQ-1:0]   req_parity_en = '0;
  logic [NREQ-1:0]   req_stop2 = '0;
  logic [NREQ-1:0]   gnt, done, err;
  logic              busy, uart_start, uart_parity_type, uart_parity_en, uart_stop2, uart_rst;
  logic [7:0]        uart_data;
  logic [3:0]        uart_length;
  logic              uart_done = 1'b0;
  logic              uart_err  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  bit tx_respond = 1'b1;
  bit tx_err_en  = 1'b0;
  bit tx_pend    = 1'b0;
  int tx_cnt     = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_length(req_length),
    .req_parity_type(req_parity_type), .req_parity_en(req_parity_en), .req_stop2(req_stop2),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .uart_start(uart_start),
    .uart_data(uart_data), .uart_length(uart_length), .uart_parity_type(uart_parity_type),
    .uart_parity_en(uart_parity_en), .uart_stop2(uart_stop2), .uart_rst(uart_rst),
    .uart_done(uart_done), .uart_err(uart_err)
  );

  always #5 tx_clk = ~tx_clk;

  // Transmitter stand-in: uart_done lands 3+L+P+T cycles after uart_start.
  // Its error flag is data[0]^data[7] when error injection is enabled.
  always @(negedge tx_clk) begin
    uart_done = 1'b0;
    uart_err  = 1'b0;
    if (!rst_n || uart_rst === 1'b1) begin
      tx_pend = 1'b0;
    end else if (tx_pend) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        uart_done = 1'b1;
        uart_err  = tx_err_en && (uart_data[0] ^ uart_data[7]);
        tx_pend   = 1'b0;
      end
    end
    if (rst_n && uart_rst === 1'b0 && uart_start === 1'b1 && tx_respond) begin
      tx_pend = 1'b1;
      tx_cnt  = 3 + int'(uart_length) + int'(uart_parity_en) + int'(uart_stop2);
    end
  end

  task automatic step();
    @(negedge tx_clk);
  endtask

  task automatic set_req(input int i, input logic r, input logic [7:0] d, input logic [3:0] l,
                         input logic pt, input logic pe, input logic s2);
    req[i]                 = r;
    req_data[i*8 +: 8]     = d;
    req_length[i*4 +: 4]   = l;
    req_parity_type[i]     = pt;
    req_parity_en[i]       = pe;
    req_stop2[i]           = s2;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] got;
    #2 rst_n = 1'b0;
    step();
    got = {gnt, done, err, busy, uart_start, uart_data, uart_length,
           uart_parity_type, uart_parity_en, uart_stop2};
    vectors++;
    if (got !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    vectors++;
    if (uart_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_uart_rst: got %b want 1", uart_rst);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if ({uart_rst, busy, gnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got rst=%b busy=%b gnt=%b want all 0", uart_rst, busy, gnt);
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 8'hA5, 4'd8, 1'b1, 1'b1, 1'b0);
    step();
    vectors++;
    if ({gnt, busy} !== {4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL single_start_state: got gnt=%b busy=%b want 0000/1", gnt, busy);
    end
    step();
    vectors++;
    if ({gnt, uart_start, err} !== {4'b0001, 1'b1, 4'b0000}) begin
      miscompares++;
      $display("FAIL single_gnt: got gnt=%b start=%b err=%b want 0001/1/0000", gnt, uart_start, err);
    end
    vectors++;
    if ({uart_data, uart_length, uart_parity_type, uart_parity_en, uart_stop2} !== {8'hA5, 4'd8, 3'b110}) begin
      miscompares++;
      $display("FAIL single_cfg: got %h/%0d/%b%b%b want a5/8/110", uart_data, uart_length,
               uart_parity_type, uart_parity_en, uart_stop2);
    end
    req[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++;
      if ({done, err, uart_start} !== '0) begin
        miscompares++;
        $display("FAIL single_quiet S+%0d: got done=%b err=%b start=%b want 0", k, done, err, uart_start);
      end
    end
    step();
    vectors++;
    if ({done, err, busy} !== {4'b0001, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL single_done S+13: got done=%b err=%b busy=%b want 0001/0000/0", done, err, busy);
    end
  endtask

  task automatic test_config();
    set_req(0, 1'b1, 8'hA5, 4'd6, 1'b0, 1'b0, 1'b1);
    step();
    step();
    vectors++;
    if ({gnt, uart_data} !== {4'b0001, 8'hA5}) begin
      miscompares++;
      $display("FAIL cfg_gnt: got gnt=%b data=%h want 0001/a5", gnt, uart_data);
    end
    req[0] = 1'b0;
    step();
    req_data[7:0] = 8'h3C;
    for (int k = 2; k <= 11; k++) begin
      step();
      vectors++;
      if (uart_data !== 8'hA5) begin
        miscompares++;
        $display("FAIL cfg_hold S+%0d: got data=%h want a5", k, uart_data);
      end
    end
    vectors++;
    if (done !== 4'b0001) begin
      miscompares++;
      $display("FAIL cfg_done S+11: got %b want 0001", done);
    end
    set_req(0, 1'b1, 8'h3C, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    vectors++;
    if ({gnt, uart_data, uart_length} !== {4'b0001, 8'h3C, 4'd5}) begin
      miscompares++;
      $display("FAIL cfg_recapture: got gnt=%b data=%h len=%0d want 0001/3c/5", gnt, uart_data, uart_length);
    end
    req[0] = 1'b0;
    repeat (9) step();
    vectors++;
    if (done !== 4'b0001) begin
      miscompares++;
      $display("FAIL cfg_done2: got %b want 0001", done);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]      rd[NREQ];
    logic [NREQ-1:0] eg, ed;
    int              gw;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = 8'($urandom);
      set_req(i, 1'b1, rd[i], 4'd5, 1'b0, 1'b0, 1'b0);
    end
    for (int t = 1; t <= 56; t++) begin
      step();
      eg = '0;
      ed = '0;
      gw = -1;
      for (int k = 0; k < 5; k++) begin
        if (t == 2 + 11 * k) begin
          eg[k % NREQ] = 1'b1;
          gw = k % NREQ;
        end
        if (t == 11 + 11 * k) ed[k % NREQ] = 1'b1;
      end
      vectors++;
      if ({gnt, done, err} !== {eg, ed, 4'b0000}) begin
        miscompares++;
        $display("FAIL rr t=%0d: got gnt=%b done=%b err=%b want %b/%b/0000", t, gnt, done, err, eg, ed);
      end
      if (gw >= 0) begin
        vectors++;
        if (uart_data !== rd[gw]) begin
          miscompares++;
          $display("FAIL rr_data t=%0d: got %h want %h", t, uart_data, rd[gw]);
        end
      end
      if (t == 46) req = '0;
    end
  endtask

  task automatic test_illegal();
    set_req(1, 1'b1, 8'h11, 4'd9, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if ({gnt, busy} !== {4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL ill_start_state: got gnt=%b busy=%b want 0000/1", gnt, busy);
    end
    step();
    vectors++;
    if ({gnt, err, uart_start, busy} !== {4'b0010, 4'b0010, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ill_gnt_err: got gnt=%b err=%b start=%b busy=%b want 0010/0010/0/0",
               gnt, err, uart_start, busy);
    end
    req[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++;
      if ({done, err, uart_start} !== '0) begin
        miscompares++;
        $display("FAIL ill_quiet k=%0d: got done=%b err=%b start=%b want 0", k, done, err, uart_start);
      end
    end
    set_req(0, 1'b1, 8'h01, 4'd5, 1'b0, 1'b0, 1'b0);
    set_req(2, 1'b1, 8'h02, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    vectors++;
    if ({gnt, uart_data} !== {4'b0100, 8'h02}) begin
      miscompares++;
      $display("FAIL ill_ptr_advance: got gnt=%b data=%h want 0100/02", gnt, uart_data);
    end
    req = '0;
    repeat (9) step();
    vectors++;
    if (done !== 4'b0100) begin
      miscompares++;
      $display("FAIL ill_next_done: got %b want 0100", done);
    end
  endtask

  task automatic test_timeout();
    tx_respond = 1'b0;
    set_req(2, 1'b1, 8'h5A, 4'd8, 1'b1, 1'b1, 1'b1);
    step();
    step();
    vectors++;
    if ({gnt, uart_start} !== {4'b0100, 1'b1}) begin
      miscompares++;
      $display("FAIL to_gnt: got gnt=%b start=%b want 0100/1", gnt, uart_start);
    end
    req[2] = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      vectors++;
      if ({err, done, uart_rst, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL to_wait S+%0d: got err=%b done=%b rst=%b busy=%b want 0/0/0/1", k, err, done, uart_rst, busy);
      end
    end
    step();
    vectors++;
    if ({err, done, uart_rst} !== {4'b0100, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL to_abort S+17: got err=%b done=%b rst=%b want 0100/0000/1", err, done, uart_rst);
    end
    tx_respond = 1'b1;
    set_req(3, 1'b1, 8'hC3, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if ({busy, uart_rst, err} !== '0) begin
      miscompares++;
      $display("FAIL to_after: got busy=%b rst=%b err=%b want 0", busy, uart_rst, err);
    end
    step();
    step();
    vectors++;
    if ({gnt, uart_start, uart_data} !== {4'b1000, 1'b1, 8'hC3}) begin
      miscompares++;
      $display("FAIL to_next_gnt: got gnt=%b start=%b data=%h want 1000/1/c3", gnt, uart_start, uart_data);
    end
    req[3] = 1'b0;
    repeat (9) step();
    vectors++;
    if ({done, err} !== {4'b1000, 4'b0000}) begin
      miscompares++;
      $display("FAIL to_next_done: got done=%b err=%b want 1000/0000", done, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    set_req(0, 1'b1, 8'h77, 4'd8, 1'b0, 1'b0, 1'b0);
    step();
    step();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_gnt: got %b want 0001", gnt);
    end
    req = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    got = {gnt, done, err, busy, uart_start, uart_data, uart_length,
           uart_parity_type, uart_parity_en, uart_stop2};
    vectors++;
    if ({got, uart_rst} !== {32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rm_async: got %h rst=%b want 0/1", got, uart_rst);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      vectors++;
      if ({done, err, uart_rst} !== '0) begin
        miscompares++;
        $display("FAIL rm_quiet k=%0d: got done=%b err=%b rst=%b want 0", k, done, err, uart_rst);
      end
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h40 + i), 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    vectors++;
    if ({gnt, uart_data} !== {4'b0001, 8'h40}) begin
      miscompares++;
      $display("FAIL rm_first_winner: got gnt=%b data=%h want 0001/40", gnt, uart_data);
    end
    req = '0;
    repeat (9) step();
    vectors++;
    if (done !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_done: got %b want 0001", done);
    end
  endtask

  // Frame-level model: each capture predicts gnt at +2, and either err with gnt
  // (illegal length) or done at gnt+4+L+P+T with the transmitter's error flag.
  task automatic test_random();
    logic [NREQ-1:0] eg[64], ed[64], ee[64];
    bit              es[64], eb[64];
    bit              pend[NREQ];
    int              gat[NREQ];
    logic [7:0]      fd[NREQ];
    logic [3:0]      fl[NREQ];
    bit              fpt[NREQ], fpe[NREQ], fs2[NREQ];
    logic [7:0]      md;
    logic [3:0]      ml;
    bit              mpt, mpe, ms2;
    int              m_ptr, next_cap, w, dcy, s;
    do_reset();
    tx_err_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      eg[i] = '0; ed[i] = '0; ee[i] = '0; es[i] = 1'b0; eb[i] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; gat[i] = -1; fd[i] = '0; fl[i] = '0; fpt[i] = 1'b0; fpe[i] = 1'b0; fs2[i] = 1'b0;
    end
    md = '0; ml = '0; mpt = 1'b0; mpe = 1'b0; ms2 = 1'b0;
    m_ptr = NREQ - 1;
    next_cap = 0;
    for (int c = 0; c < 520; c++) begin
      s = c % 64;
      vectors++;
      if ({gnt, done, err} !== {eg[s], ed[s], ee[s]}) begin
        miscompares++;
        $display("FAIL rnd_pulses c=%0d: got gnt=%b done=%b err=%b want %b/%b/%b",
                 c, gnt, done, err, eg[s], ed[s], ee[s]);
      end
      vectors++;
      if ({uart_start, busy, uart_rst} !== {es[s], eb[s], 1'b0}) begin
        miscompares++;
        $display("FAIL rnd_ctl c=%0d: got start=%b busy=%b rst=%b want %b/%b/0",
                 c, uart_start, busy, uart_rst, es[s], eb[s]);
      end
      vectors++;
      if ({uart_data, uart_length, uart_parity_type, uart_parity_en, uart_stop2} !== {md, ml, mpt, mpe, ms2}) begin
        miscompares++;
        $display("FAIL rnd_cfg c=%0d: got %h/%0d/%b%b%b want %h/%0d/%b%b%b", c, uart_data, uart_length,
                 uart_parity_type, uart_parity_en, uart_stop2, md, ml, mpt, mpe, ms2);
      end
      eg[s] = '0; ed[s] = '0; ee[s] = '0; es[s] = 1'b0; eb[s] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (gat[i] == c) begin
          gat[i]  = -1;
          pend[i] = 1'b0;
        end
        if (!pend[i] && c < 440 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          fd[i]   = 8'($urandom);
          fl[i]   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(5, 8));
          fpt[i]  = 1'($urandom);
          fpe[i]  = 1'($urandom);
          fs2[i]  = 1'($urandom);
        end
        set_req(i, pend[i], fd[i], fl[i], fpt[i], fpe[i], fs2[i]);
      end
      if (c >= next_cap) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && pend[(m_ptr + k) % NREQ] && gat[(m_ptr + k) % NREQ] < 0) w = (m_ptr + k) % NREQ;
        end
        if (w >= 0) begin
          m_ptr = w;
          gat[w] = c + 2;
          md = fd[w]; ml = fl[w]; mpt = fpt[w]; mpe = fpe[w]; ms2 = fs2[w];
          eg[(c + 2) % 64][w] = 1'b1;
          eb[(c + 1) % 64] = 1'b1;
          if (fl[w] >= 4'd5 && fl[w] <= 4'd8) begin
            dcy = c + 6 + int'(fl[w]) + int'(fpe[w]) + int'(fs2[w]);
            es[(c + 2) % 64] = 1'b1;
            ed[dcy % 64][w] = 1'b1;
            if (fd[w][0] ^ fd[w][7]) ee[dcy % 64][w] = 1'b1;
            for (int t = c + 2; t < dcy; t++) eb[t % 64] = 1'b1;
            next_cap = dcy;
          end else begin
            ee[(c + 2) % 64][w] = 1'b1;
            next_cap = c + 2;
          end
        end
      end
      step();
    end
    req = '0;
    tx_err_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_config();
    test_round_robin();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
